// File: rtl/instruction_memory_if.sv
// Fetch and byte-serial load port bundle for instruction_memory.
interface instruction_memory_if #(
    parameter int unsigned DEPTH_WORDS = 1024
) ();
    localparam int unsigned CW = $clog2(DEPTH_WORDS) + 1;

    logic [31:0]   fetch_address;
    logic [31:0]   fetch_data;
    logic          fetch_fault;
    logic          load_start;
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic          load_overflow;
    logic [CW-1:0] loaded_words;

    modport master (
        output fetch_address, load_start, load_valid, load_byte, load_last,
        input  fetch_data, fetch_fault, load_ready, load_done, load_overflow, loaded_words
    );

    modport slave (
        input  fetch_address, load_start, load_valid, load_byte, load_last,
        output fetch_data, fetch_fault, load_ready, load_done, load_overflow, loaded_words
    );
endinterface

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: combinational fetch read, byte-serial
// valid/ready load port that packs little-endian bytes into words.
module instruction_memory #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000,
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
    input  logic clk,
    input  logic reset,
    instruction_memory_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {ST_IDLE, ST_LOAD} state_t;

    state_t        r_state;
    logic [CW-1:0] r_wr_ptr;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_word;
    logic          r_load_done;
    logic          r_load_overflow;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_full;
    logic          w_accept;
    logic          w_wr_en;
    logic [31:0]   w_wr_data;
    logic [31:0]   w_off;
    logic          w_fault;
    logic [31:0]   w_rd_data;

    // wr_ptr never exceeds DEPTH_WORDS, so its top bit alone flags a full array
    assign w_full   = r_wr_ptr[AW];
    assign w_accept = (r_state == ST_LOAD) && bus.load_valid;
    assign w_wr_en  = w_accept && !w_full && ((r_byte_idx == 2'd3) || bus.load_last);

    // Incoming byte lands at byte_idx; bytes above it in a partial word are zero
    always_comb begin
        w_wr_data = 32'h0;
        case (r_byte_idx)
            2'd0:    w_wr_data = {24'h0, bus.load_byte};
            2'd1:    w_wr_data = {16'h0, bus.load_byte, r_word[7:0]};
            2'd2:    w_wr_data = {8'h0, bus.load_byte, r_word[15:0]};
            default: w_wr_data = {bus.load_byte, r_word[23:0]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_wr_ptr        <= '0;
            r_byte_idx      <= 2'd0;
            r_word          <= 24'h0;
            r_load_done     <= 1'b0;
            r_load_overflow <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        r_state         <= ST_LOAD;
                        r_wr_ptr        <= '0;
                        r_byte_idx      <= 2'd0;
                        r_load_overflow <= 1'b0;
                    end
                end
                default: begin
                    if (bus.load_valid) begin
                        if (w_full) begin
                            r_load_overflow <= 1'b1;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            if (w_wr_en) begin
                                r_wr_ptr <= r_wr_ptr + CW'(1);
                            end else begin
                                case (r_byte_idx)
                                    2'd0:    r_word[7:0]   <= bus.load_byte;
                                    2'd1:    r_word[15:8]  <= bus.load_byte;
                                    default: r_word[23:16] <= bus.load_byte;
                                endcase
                            end
                        end
                        if (bus.load_last) begin
                            r_state     <= ST_IDLE;
                            r_load_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Array storage is never reset: contents survive reset and later sessions
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
        end
    end

    // BASE_ADDRESS is word-aligned, so the low offset bits equal the address bits
    assign w_off     = bus.fetch_address - BASE_ADDRESS;
    assign w_fault   = (w_off[1:0] != 2'd0) || (w_off[31:AW+2] != '0);
    assign w_rd_data = r_mem[w_off[AW+1:2]];

    assign bus.fetch_fault   = w_fault;
    assign bus.fetch_data    = (w_fault || (r_state == ST_LOAD)) ? NOP_WORD : w_rd_data;
    assign bus.load_ready    = (r_state == ST_LOAD);
    assign bus.load_done     = r_load_done;
    assign bus.load_overflow = r_load_overflow;
    assign bus.loaded_words  = r_wr_ptr;
endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: one full-size instance and one
// four-word instance for the array-full behaviour.
module tb_instruction_memory;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] lb[$];

    instruction_memory_if #(.DEPTH_WORDS(1024)) ifa ();
    instruction_memory_if #(.DEPTH_WORDS(4))    ifb ();

    instruction_memory #(.BASE_ADDRESS(32'h1000), .DEPTH_WORDS(1024), .NOP_WORD(NOP))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    instruction_memory #(.BASE_ADDRESS(32'h1000), .DEPTH_WORDS(4), .NOP_WORD(NOP))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sb, input logic st, input logic v, input logic [7:0] b, input logic l);
        if (sb) begin
            ifb.load_start = st; ifb.load_valid = v; ifb.load_byte = b; ifb.load_last = l;
        end else begin
            ifa.load_start = st; ifa.load_valid = v; ifa.load_byte = b; ifa.load_last = l;
        end
    endtask

    task automatic start_session(input bit sb);
        drive(sb, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        drive(sb, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Send lb[]; an idle gap of 3 cycles is inserted before index gap_at
    task automatic send_bytes(input bit sb, input int gap_at, input bit with_last);
        for (int i = 0; i < lb.size(); i++) begin
            if (i == gap_at) begin
                drive(sb, 1'b0, 1'b0, 8'h00, 1'b0);
                repeat (3) tick();
            end
            drive(sb, 1'b0, 1'b1, lb[i], (with_last && (i == lb.size() - 1)));
            tick();
        end
        drive(sb, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic fetch_a(input string tag, input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_f);
        ifa.fetch_address = addr;
        #1;
        chk({tag, "_data"}, ifa.fetch_data, exp_d);
        chk({tag, "_fault"}, 32'(ifa.fetch_fault), 32'(exp_f));
    endtask

    task automatic fetch_b(input string tag, input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_f);
        ifb.fetch_address = addr;
        #1;
        chk({tag, "_data"}, ifb.fetch_data, exp_d);
        chk({tag, "_fault"}, 32'(ifb.fetch_fault), 32'(exp_f));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        ifa.fetch_address = 32'h1000;
        ifb.fetch_address = 32'h1000;
        #12 reset = 1'b0;
        tick();

        // Reset state
        chk("rst_ready_a", 32'(ifa.load_ready), 32'd0);
        chk("rst_done_a", 32'(ifa.load_done), 32'd0);
        chk("rst_ovf_a", 32'(ifa.load_overflow), 32'd0);
        chk("rst_words_a", 32'(ifa.loaded_words), 32'd0);
        chk("rst_words_b", 32'(ifb.loaded_words), 32'd0);

        // Zero word 0, then fetch it
        lb = '{8'h00, 8'h00, 8'h00, 8'h00};
        start_session(1'b0);
        send_bytes(1'b0, -1, 1'b1);
        tick();
        fetch_a("t1_fetch1000", 32'h1000, 32'h0000_0000, 1'b0);

        // Two-word program
        lb = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        start_session(1'b0);
        chk("t2_ready_in_load", 32'(ifa.load_ready), 32'd1);
        send_bytes(1'b0, -1, 1'b1);
        chk("t2_done_pulse", 32'(ifa.load_done), 32'd1);
        chk("t2_ready_idle", 32'(ifa.load_ready), 32'd0);
        chk("t2_words", 32'(ifa.loaded_words), 32'd2);
        tick();
        chk("t2_done_low", 32'(ifa.load_done), 32'd0);
        fetch_a("t2_fetch1000", 32'h1000, 32'h0000_0013, 1'b0);
        fetch_a("t2_fetch1004", 32'h1004, 32'h0010_0093, 1'b0);

        // Fault boundaries
        fetch_a("t3_misalign", 32'h1002, NOP, 1'b1);
        fetch_a("t3_below", 32'h0FFC, NOP, 1'b1);
        fetch_a("t3_end", 32'h2000, NOP, 1'b1);
        ifa.fetch_address = 32'h1FFC;
        #1 chk("t3_last_fault", 32'(ifa.fetch_fault), 32'd0);

        // Partial final word with a gap in load_valid
        lb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        start_session(1'b0);
        send_bytes(1'b0, 2, 1'b1);
        chk("t4_done_pulse", 32'(ifa.load_done), 32'd1);
        chk("t4_words", 32'(ifa.loaded_words), 32'd2);
        tick();
        fetch_a("t4_fetch1000", 32'h1000, 32'hDDCC_BBAA, 1'b0);
        fetch_a("t4_fetch1004", 32'h1004, 32'h0000_00EE, 1'b0);

        // Four-word instance: fill, overflow, fetch blocked during load
        lb.delete();
        for (int i = 0; i < 16; i++) lb.push_back(8'(i + 1));
        start_session(1'b1);
        fetch_b("t5_fetch_in_load", 32'h1000, NOP, 1'b0);
        send_bytes(1'b1, -1, 1'b0);
        chk("t5_full_ready", 32'(ifb.load_ready), 32'd1);
        chk("t5_full_ovf0", 32'(ifb.load_overflow), 32'd0);
        chk("t5_full_words", 32'(ifb.loaded_words), 32'd4);
        lb = '{8'h11, 8'h12};
        send_bytes(1'b1, -1, 1'b1);
        chk("t5_done_pulse", 32'(ifb.load_done), 32'd1);
        chk("t5_ovf", 32'(ifb.load_overflow), 32'd1);
        chk("t5_words", 32'(ifb.loaded_words), 32'd4);
        tick();
        fetch_b("t5_fetch1000", 32'h1000, 32'h0403_0201, 1'b0);
        fetch_b("t5_fetch100c", 32'h100C, 32'h100F_0E0D, 1'b0);
        fetch_b("t5_fetch1010", 32'h1010, NOP, 1'b1);
        start_session(1'b1);
        chk("t5_ovf_cleared", 32'(ifb.load_overflow), 32'd0);
        chk("t5_words_cleared", 32'(ifb.loaded_words), 32'd0);
        lb = '{8'h55};
        send_bytes(1'b1, -1, 1'b1);
        chk("t5_words_reload", 32'(ifb.loaded_words), 32'd1);
        tick();
        fetch_b("t5_fetch_reload", 32'h1000, 32'h0000_0055, 1'b0);

        // Reset in the middle of a session
        lb = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        start_session(1'b0);
        send_bytes(1'b0, -1, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_ready", 32'(ifa.load_ready), 32'd0);
        chk("t6_words", 32'(ifa.loaded_words), 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("t6_no_done", 32'(ifa.load_done), 32'd0);
        fetch_a("t6_word0", 32'h1000, 32'h1413_1211, 1'b0);
        fetch_a("t6_word1", 32'h1004, 32'h0000_00EE, 1'b0);
        lb = '{8'h21, 8'h22, 8'h23, 8'h24};
        start_session(1'b0);
        send_bytes(1'b0, -1, 1'b1);
        chk("t6_words_restart", 32'(ifa.loaded_words), 32'd1);
        tick();
        fetch_a("t6_restart0", 32'h1000, 32'h2423_2221, 1'b0);
        fetch_a("t6_restart1", 32'h1004, 32'h0000_00EE, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
